rsa_encrypt: RTL and testbench

RSA_ENCRYPT -- requirements
Module: rsa_encrypt

---
 rtl/rsa_pkg.sv | 17 +
 rtl/rsa_encrypt_mod_mult.sv | 77 +++++++
 rtl/rsa_encrypt.sv | 170 +++++++++++++++++
 tb/tb_rsa_encrypt.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared RSA definitions: FSM state encoding and the default operand width.
// Reused by the encrypt, decrypt and key-generation blocks.
package rsa_pkg;

  // Default operand width in bits
  localparam int RSA_DEFAULT_W = 8;

  // Exponentiation controller states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SQR  = 3'd2,
    ST_MUL  = 3'd3,
    ST_DONE = 3'd4
  } rsa_state_e;

endpackage

// File: rtl/rsa_encrypt_mod_mult.sv
// mod_mult: W-cycle interleaved shift-add modular multiplier, r = a*b mod n.
// The multiplier b is scanned MSB first. The first step is taken on the
// start edge itself, so the product is ready after exactly W cycles and
// done_o pulses in the cycle that follows the last step.
// Operands must satisfy a, b < n.
module mod_mult
  import rsa_pkg::*;
#(
  parameter int W = RSA_DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] n_i,
  output logic         done_o,
  output logic [W-1:0] r_o
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;

  logic [W-1:0]  a_q, b_q, n_q, r_q;
  logic [CW-1:0] cnt_q;
  logic          run_q, done_q;

  logic [W+1:0]  op_r, op_a, op_n, sum, sub1, sub2;
  logic          op_bit;

  // One interleaved step: r = 2r (+a), then two conditional subtractions of n
  always_comb begin
    op_r   = start_i ? '0 : {2'b00, r_q};
    op_a   = start_i ? {2'b00, a_i} : {2'b00, a_q};
    op_n   = start_i ? {2'b00, n_i} : {2'b00, n_q};
    op_bit = start_i ? b_i[W-1] : b_q[W-1];
    sum    = {op_r[W:0], 1'b0} + (op_bit ? op_a : '0);
    sub1   = (sum  >= op_n) ? (sum  - op_n) : sum;
    sub2   = (sub1 >= op_n) ? (sub1 - op_n) : sub1;
  end

  // Operand latching, step sequencing and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      n_q    <= '0;
      r_q    <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        a_q    <= a_i;
        b_q    <= b_i << 1;
        n_q    <= n_i;
        r_q    <= sub2[W-1:0];
        cnt_q  <= CW'(W - 2);
        run_q  <= (W > 1);
        done_q <= (W == 1);
      end else if (run_q) begin
        r_q <= sub2[W-1:0];
        b_q <= b_q << 1;
        if (cnt_q == '0) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end
  end

  assign done_o = done_q;
  assign r_o    = r_q;

endmodule

// File: rtl/rsa_encrypt.sv
// rsa_encrypt: c = m^e mod n by left-to-right square-and-multiply over all W
// exponent bits. Each bit costs a W-cycle square and a W-cycle multiply; the
// multiply result is kept only when the bit is 1, so latency is fixed.
// Optional build macro RSA_ENC_RANGE_CHECK_EN adds the err port and the
// m<n, n>=2 operand check.
module rsa_encrypt
  import rsa_pkg::*;
#(
  parameter int W = RSA_DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] m,
  input  logic [W-1:0] e,
  input  logic [W-1:0] n,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] c
`ifdef RSA_ENC_RANGE_CHECK_EN
  ,
  output logic         err
`endif
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam logic [W-1:0] ONE = W'(1);

  rsa_state_e    state_q;
  logic [W-1:0]  m_q, e_q, n_q, acc_q, c_q;
  logic [IW-1:0] idx_q;
  logic          ready_q, busy_q, done_q;

  logic          mm_start, mm_done, keep;
  logic [W-1:0]  mm_a, mm_b, mm_r;

`ifdef RSA_ENC_RANGE_CHECK_EN
  localparam logic [W-1:0] TWO = W'(2);
  logic err_q;
  logic range_bad;
  assign range_bad = (m_q >= n_q) || (n_q < TWO);
`endif

  assign keep = e_q[idx_q];

  // Launch the shared multiplier back-to-back as each phase hands over
  always_comb begin
    mm_start = 1'b0;
    mm_a     = '0;
    mm_b     = '0;
    case (state_q)
      ST_LOAD: begin
`ifdef RSA_ENC_RANGE_CHECK_EN
        mm_start = !range_bad;
`else
        mm_start = 1'b1;
`endif
        mm_a = ONE;
        mm_b = ONE;
      end
      ST_SQR: if (mm_done) begin
        mm_start = 1'b1;
        mm_a     = mm_r;
        mm_b     = m_q;
      end
      ST_MUL: if (mm_done && idx_q != '0) begin
        mm_start = 1'b1;
        mm_a     = keep ? mm_r : acc_q;
        mm_b     = keep ? mm_r : acc_q;
      end
      default: ;
    endcase
  end

  mod_mult #(.W(W)) u_mod_mult (
    .clk    (clk),
    .rst    (rst),
    .start_i(mm_start),
    .a_i    (mm_a),
    .b_i    (mm_b),
    .n_i    (n_q),
    .done_o (mm_done),
    .r_o    (mm_r)
  );

  // Controller FSM with registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      e_q     <= '0;
      n_q     <= '0;
      acc_q   <= '0;
      c_q     <= '0;
      idx_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef RSA_ENC_RANGE_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (start) begin
          m_q     <= m;
          e_q     <= e;
          n_q     <= n;
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= ST_LOAD;
`ifdef RSA_ENC_RANGE_CHECK_EN
          err_q   <= 1'b0;
`endif
        end
        ST_LOAD: begin
          acc_q <= ONE;
          idx_q <= IW'(W - 1);
`ifdef RSA_ENC_RANGE_CHECK_EN
          if (range_bad) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_SQR;
          end
`else
          state_q <= ST_SQR;
`endif
        end
        ST_SQR: if (mm_done) begin
          acc_q   <= mm_r;
          state_q <= ST_MUL;
        end
        ST_MUL: if (mm_done) begin
          if (keep) acc_q <= mm_r;
          if (idx_q == '0) begin
            c_q     <= keep ? mm_r : acc_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_DONE;
          end else begin
            idx_q   <= idx_q - 1'b1;
            state_q <= ST_SQR;
          end
        end
        ST_DONE: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign c     = c_q;
`ifdef RSA_ENC_RANGE_CHECK_EN
  assign err   = err_q;
`endif

endmodule

// File: tb/tb_rsa_encrypt.sv
// Scoreboard bench for rsa_encrypt: the driver pushes expected results from a
// plain-arithmetic modular exponentiation model; a monitor pops on every done.
// Latency is counted with cycle 1 = the cycle right after the accepting edge.
module tb_rsa_encrypt;

  localparam int W       = 8;
  localparam int LAT_RUN = 2 * W * W + 2;
  localparam int LAT_ERR = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] m = '0, e = '0, n = '0;
  logic         ready, busy, done;
  logic [W-1:0] c;
`ifdef RSA_ENC_RANGE_CHECK_EN
  logic         err;
`endif

  rsa_encrypt #(.W(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .m    (m),
    .e    (e),
    .n    (n),
    .ready(ready),
    .busy (busy),
    .done (done),
    .c    (c)
`ifdef RSA_ENC_RANGE_CHECK_EN
    ,
    .err  (err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] c;
    logic         err;
    int           lat;
    int           acc_cyc;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] model_c = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // m^e mod n by repeated multiplication
  function automatic logic [W-1:0] ref_pow(input int mm, input int ee, input int nn);
    longint r;
    r = 1 % nn;
    for (int i = 0; i < ee; i++) r = (r * mm) % nn;
    return r[W-1:0];
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic issue(input int mi, input int ei, input int ni);
    int   t;
    exp_t x;
    t = 0;
    while (!ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("ready_wait", ready, 1);
    start = 1'b1;
    m = mi[W-1:0];
    e = ei[W-1:0];
    n = ni[W-1:0];
    @(negedge clk);
    start = 1'b0;
    m = W'($urandom);
    e = W'($urandom);
    n = W'($urandom);
    chk("accept_busy", busy, 1);
    chk("accept_ready", ready, 0);
`ifdef RSA_ENC_RANGE_CHECK_EN
    chk("err_clear_on_start", err, 0);
    if (mi >= ni || ni < 2) begin
      x.c = model_c;
      x.err = 1'b1;
      x.lat = LAT_ERR;
    end else begin
      x.c = ref_pow(mi, ei, ni);
      x.err = 1'b0;
      x.lat = LAT_RUN;
    end
`else
    x.c = ref_pow(mi, ei, ni);
    x.err = 1'b0;
    x.lat = LAT_RUN;
`endif
    x.acc_cyc = cyc;
    model_c = x.c;
    sb.push_back(x);
    $display("issue m=%0d e=%0d n=%0d -> expect c=%0d", mi, ei, ni, x.c);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", sb.size(), 0);
    @(negedge clk);
  endtask

  // Monitor: pop and compare on each done pulse
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        exp_t x;
        chk("done_ready_excl", ready, 0);
        chk("done_single_pulse", prev_done, 0);
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          x = sb.pop_front();
          chk("result_c", c, x.c);
          chk("latency", cyc - x.acc_cyc + 1, x.lat);
`ifdef RSA_ENC_RANGE_CHECK_EN
          chk("err_flag", err, x.err);
`endif
          $display("done c=%0d expected=%0d lat=%0d", c, x.c, cyc - x.acc_cyc + 1);
        end
      end
      prev_done <= done;
    end else begin
      prev_done <= 1'b0;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int nn, mm, ee;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_ready", ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_c", c, 0);
`ifdef RSA_ENC_RANGE_CHECK_EN
    chk("reset_err", err, 0);
`endif

    // Directed vectors
    issue(88, 7, 187);  drain();
    issue(11, 23, 187); drain();
    issue(5, 0, 187);   drain();
    issue(0, 5, 187);   drain();

    // Start during a running job must be ignored
    issue(88, 7, 187);
    repeat (38) @(negedge clk);
    start = 1'b1;
    m = 8'd99;
    e = 8'd3;
    n = 8'd187;
    @(negedge clk);
    chk("ignored_start_busy", busy, 1);
    start = 1'b0;
    drain();

    // Reset mid-job aborts without done
    issue(88, 7, 187);
    repeat (58) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    model_c = '0;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_c", c, 0);
    repeat (150) @(negedge clk);
    issue(11, 23, 187); drain();

`ifdef RSA_ENC_RANGE_CHECK_EN
    // Out-of-range operands: early done, err set, c held
    issue(200, 7, 187); drain();
    issue(1, 5, 1);     drain();
    issue(88, 7, 187);  drain();
`endif

    // Randomized jobs with legal operands, back to back
    for (int k = 0; k < 12; k++) begin
      nn = $urandom_range(255, 2);
      mm = $urandom_range(nn - 1, 0);
      ee = $urandom_range(255, 0);
      issue(mm, ee, nn);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
